// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Purpose  : Shared definitions for the pong ball engine: FSM state
//            encoding, paddle hit-zone encoding, direction and player
//            constants, datapath widths and a saturating speed helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

  // Datapath widths. Internal geometry math runs at COORD_W so that sums
  // such as x+vx or y+BALL_SIZE never wrap for any on-screen position.
  localparam int COORD_W = 12;
  localparam int X_W     = 11;
  localparam int Y_W     = 10;
  localparam int SPEED_W = 8;
  localparam int SCORE_W = 4;
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_MOVE  = 3'd2,
    ST_SCORE = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // Where on the paddle face the ball centre landed.
  typedef enum logic [1:0] {
    ZONE_MID = 2'd0,
    ZONE_TOP = 2'd1,
    ZONE_BOT = 2'd2
  } zone_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  localparam logic PLAYER1 = 1'b0;
  localparam logic PLAYER2 = 1'b1;

  function automatic logic [SPEED_W-1:0] sat_inc(input logic [SPEED_W-1:0] v,
                                                 input logic [SPEED_W-1:0] lim);
    return (v >= lim) ? lim : v + SPEED_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_paddle_hit.sv
`default_nettype none
// ============================================================================
// Module   : pong_paddle_hit
// Purpose  : Combinational paddle collision test and hit-zone decode for
//            one paddle.
// Ports    : ball_x, ball_y - ball origin (COORD_W)
//            pad_y          - paddle origin Y (COORD_W)
//            dir_x          - current horizontal ball direction
//            hit            - ball overlaps paddle while moving toward it
//            zone           - top / middle / bottom third of the paddle
// Revision : 1.0 - initial release
// ============================================================================
module pong_paddle_hit
  import pong_pkg::*;
#(
  parameter int   PAD_X     = 40,
  parameter int   PAD_W     = 10,
  parameter int   PAD_H     = 50,
  parameter int   BALL_SIZE = 10,
  parameter logic TOWARD    = DIR_LEFT
) (
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] pad_y,
  input  logic               dir_x,
  output logic               hit,
  output zone_e              zone
);

  localparam logic [COORD_W-1:0] PAD_LO   = COORD_W'(PAD_X);
  localparam logic [COORD_W-1:0] PAD_HI   = COORD_W'(PAD_X + PAD_W);
  localparam logic [COORD_W-1:0] BALL_SZ  = COORD_W'(BALL_SIZE);
  localparam logic [COORD_W-1:0] HALF_SZ  = COORD_W'(BALL_SIZE / 2);
  localparam logic [COORD_W-1:0] PAD_LEN  = COORD_W'(PAD_H);
  localparam logic [COORD_W-1:0] ZONE_ONE = COORD_W'(PAD_H / 3);
  localparam logic [COORD_W-1:0] ZONE_TWO = COORD_W'((2 * PAD_H) / 3);

  logic [COORD_W-1:0] cy;
  logic [COORD_W-1:0] off;
  logic               x_overlap;
  logic               y_inside;

  always_comb begin
    cy        = ball_y + HALF_SZ;
    off       = cy - pad_y;   // only meaningful when y_inside
    x_overlap = (ball_x < PAD_HI) && ((ball_x + BALL_SZ) > PAD_LO);
    y_inside  = (cy >= pad_y) && (cy < (pad_y + PAD_LEN));
    hit       = x_overlap && y_inside && (dir_x == TOWARD);

    zone = ZONE_MID;
    if (off < ZONE_ONE) begin
      zone = ZONE_TOP;
    end else if (off >= ZONE_TWO) begin
      zone = ZONE_BOT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pong_ball_engine.sv
`default_nettype none
// ============================================================================
// Module   : pong_ball_engine
// Purpose  : Ball / paddle / score engine for two-player pong. Advances the
//            game once per tick: serve countdown, ball motion with wall
//            bounce, paddle deflection with hit-zone angle control, scoring
//            and match end.
// Ports    : clk, reset (async, active low), tick (frame enable),
//            start (level, begins match), pause (level, freezes play),
//            p1_y/p2_y paddle origin Y,
//            ball_x/ball_y ball origin, score1/score2, state_o,
//            ball_active (MOVE), game_over (OVER), winner (0=P1, 1=P2).
// Revision : 1.0 - initial release
// ============================================================================
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 10,
  parameter int PAD_W       = 10,
  parameter int PAD_H       = 50,
  parameter int P1_X        = 40,
  parameter int P2_X        = 600,
  parameter int SPEED_INIT  = 1,
  parameter int SPEED_MAX   = 8,
  parameter int SCORE_MAX   = 9,
  parameter int SERVE_TICKS = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic              pause,
  input  logic [9:0]        p1_y,
  input  logic [9:0]        p2_y,
  output logic [10:0]       ball_x,
  output logic [9:0]        ball_y,
  output logic [3:0]        score1,
  output logic [3:0]        score2,
  output logic [2:0]        state_o,
  output logic              ball_active,
  output logic              game_over,
  output logic              winner
);

  localparam logic [X_W-1:0]     CENTRE_X   = X_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [Y_W-1:0]     CENTRE_Y   = Y_W'((V_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] X_LIMIT    = COORD_W'(H_RES - BALL_SIZE);
  localparam logic [COORD_W-1:0] Y_LIMIT    = COORD_W'(V_RES - BALL_SIZE);
  localparam logic [Y_W-1:0]     Y_MAX      = Y_W'(V_RES - BALL_SIZE);
  localparam logic [X_W-1:0]     P1_FACE    = X_W'(P1_X + PAD_W);
  localparam logic [X_W-1:0]     P2_FACE    = X_W'(P2_X - BALL_SIZE);
  localparam logic [SPEED_W-1:0] SPD_INIT   = SPEED_W'(SPEED_INIT);
  localparam logic [SPEED_W-1:0] SPD_MAX    = SPEED_W'(SPEED_MAX);
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_END  = SCORE_W'(SCORE_MAX);

  state_e               state_q,       state_d;
  logic [X_W-1:0]       bx_q,          bx_d;
  logic [Y_W-1:0]       by_q,          by_d;
  logic                 dir_x_q,       dir_x_d;
  logic                 dir_y_q,       dir_y_d;
  logic [SPEED_W-1:0]   vx_q,          vx_d;
  logic [SPEED_W-1:0]   vy_q,          vy_d;
  logic [CNT_W-1:0]     cnt_q,         cnt_d;
  logic [SCORE_W-1:0]   score1_q,      score1_d;
  logic [SCORE_W-1:0]   score2_q,      score2_d;
  logic                 scorer_q,      scorer_d;
  logic                 winner_q,      winner_d;
  logic                 ball_active_q, ball_active_d;
  logic                 game_over_q,   game_over_d;

  // Widened copies for overflow-free comparisons.
  logic [COORD_W-1:0]   bx_w, by_w, vx_w, vy_w, pad1_w, pad2_w;
  logic                 hit1_w, hit2_w;
  zone_e                zone1_w, zone2_w, zone_sel;
  logic [SCORE_W-1:0]   score_inc_w;

  assign bx_w   = COORD_W'(bx_q);
  assign by_w   = COORD_W'(by_q);
  assign vx_w   = COORD_W'(vx_q);
  assign vy_w   = COORD_W'(vy_q);
  assign pad1_w = COORD_W'(p1_y);
  assign pad2_w = COORD_W'(p2_y);

  assign score_inc_w = ((scorer_q == PLAYER1) ? score1_q : score2_q) + SCORE_W'(1);

  pong_paddle_hit #(
    .PAD_X     (P1_X),
    .PAD_W     (PAD_W),
    .PAD_H     (PAD_H),
    .BALL_SIZE (BALL_SIZE),
    .TOWARD    (DIR_LEFT)
  ) u_hit_p1 (
    .ball_x (bx_w),
    .ball_y (by_w),
    .pad_y  (pad1_w),
    .dir_x  (dir_x_q),
    .hit    (hit1_w),
    .zone   (zone1_w)
  );

  pong_paddle_hit #(
    .PAD_X     (P2_X),
    .PAD_W     (PAD_W),
    .PAD_H     (PAD_H),
    .BALL_SIZE (BALL_SIZE),
    .TOWARD    (DIR_RIGHT)
  ) u_hit_p2 (
    .ball_x (bx_w),
    .ball_y (by_w),
    .pad_y  (pad2_w),
    .dir_x  (dir_x_q),
    .hit    (hit2_w),
    .zone   (zone2_w)
  );

  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    cnt_d    = cnt_q;
    score1_d = score1_q;
    score2_d = score2_q;
    scorer_d = scorer_q;
    winner_d = winner_q;
    zone_sel = hit1_w ? zone1_w : zone2_w;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SERVE;
          cnt_d   = SERVE_LOAD;
        end
      end

      ST_SERVE: begin
        // A count of 1 or 0 both launch on this tick.
        if (tick && !pause) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_MOVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      ST_MOVE: begin
        if (tick && !pause) begin
          if (hit1_w || hit2_w) begin
            // Deflection: snap to the face so the ball never sits inside
            // the paddle, and leave Y alone for this tick.
            dir_x_d = hit1_w ? DIR_RIGHT : DIR_LEFT;
            bx_d    = hit1_w ? P1_FACE : P2_FACE;
            vx_d    = sat_inc(vx_q, SPD_MAX);
            if (zone_sel == ZONE_TOP) begin
              dir_y_d = DIR_UP;
              vy_d    = sat_inc(vy_q, SPD_MAX);
            end else if (zone_sel == ZONE_BOT) begin
              dir_y_d = DIR_DOWN;
              vy_d    = sat_inc(vy_q, SPD_MAX);
            end
          end else if ((dir_x_q == DIR_LEFT) && (bx_w < vx_w)) begin
            state_d  = ST_SCORE;
            scorer_d = PLAYER2;
          end else if ((dir_x_q == DIR_RIGHT) && ((bx_w + vx_w) > X_LIMIT)) begin
            state_d  = ST_SCORE;
            scorer_d = PLAYER1;
          end else begin
            bx_d = (dir_x_q == DIR_LEFT) ? X_W'(bx_w - vx_w) : X_W'(bx_w + vx_w);
            if (dir_y_q == DIR_UP) begin
              if (by_w <= vy_w) begin
                by_d    = '0;
                dir_y_d = DIR_DOWN;
              end else begin
                by_d = Y_W'(by_w - vy_w);
              end
            end else begin
              if ((by_w + vy_w) >= Y_LIMIT) begin
                by_d    = Y_MAX;
                dir_y_d = DIR_UP;
              end else begin
                by_d = Y_W'(by_w + vy_w);
              end
            end
          end
        end
      end

      ST_SCORE: begin
        if (scorer_q == PLAYER1) begin
          score1_d = score_inc_w;
        end else begin
          score2_d = score_inc_w;
        end
        if (score_inc_w == SCORE_END) begin
          state_d  = ST_OVER;
          winner_d = scorer_q;
        end else begin
          state_d = ST_SERVE;
          bx_d    = CENTRE_X;
          by_d    = CENTRE_Y;
          vx_d    = SPD_INIT;
          vy_d    = SPD_INIT;
          dir_y_d = DIR_UP;
          // Serve toward the player who just conceded.
          dir_x_d = (scorer_q == PLAYER1) ? DIR_RIGHT : DIR_LEFT;
          cnt_d   = SERVE_LOAD;
        end
      end

      ST_OVER: begin
        if (start) begin
          state_d  = ST_SERVE;
          score1_d = '0;
          score2_d = '0;
          winner_d = 1'b0;
          bx_d     = CENTRE_X;
          by_d     = CENTRE_Y;
          vx_d     = SPD_INIT;
          vy_d     = SPD_INIT;
          dir_x_d  = DIR_RIGHT;
          dir_y_d  = DIR_UP;
          cnt_d    = SERVE_LOAD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ball_active_d = (state_d == ST_MOVE);
    game_over_d   = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      bx_q          <= CENTRE_X;
      by_q          <= CENTRE_Y;
      dir_x_q       <= DIR_RIGHT;
      dir_y_q       <= DIR_UP;
      vx_q          <= SPD_INIT;
      vy_q          <= SPD_INIT;
      cnt_q         <= '0;
      score1_q      <= '0;
      score2_q      <= '0;
      scorer_q      <= PLAYER1;
      winner_q      <= 1'b0;
      ball_active_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bx_q          <= bx_d;
      by_q          <= by_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      vx_q          <= vx_d;
      vy_q          <= vy_d;
      cnt_q         <= cnt_d;
      score1_q      <= score1_d;
      score2_q      <= score2_d;
      scorer_q      <= scorer_d;
      winner_q      <= winner_d;
      ball_active_q <= ball_active_d;
      game_over_q   <= game_over_d;
    end
  end

  assign ball_x      = bx_q;
  assign ball_y      = by_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign state_o     = state_q;
  assign ball_active = ball_active_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_ball_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_ball_engine
// Purpose  : Self-checking bench for pong_ball_engine. A behavioural game
//            model written from the game rules tracks the expected outputs
//            every cycle; a small vector table and hand-written sequences
//            pin down reset, serve timing, wall bounce, goals and match end.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_ball_engine;

  localparam int H_RES = 640, V_RES = 480, BALL = 10, PAD_W = 10, PAD_H = 50;
  localparam int P1_X = 40, P2_X = 600, SPD_INIT = 1, SPD_MAX = 8;
  localparam int SCORE_MAX = 9, SERVE_TICKS = 60;
  localparam int CX = (H_RES - BALL) / 2, CY = (V_RES - BALL) / 2;
  localparam int S_IDLE = 0, S_SERVE = 1, S_MOVE = 2, S_SCORE = 3, S_OVER = 4;

  logic        clk = 1'b0, reset = 1'b0, tick = 1'b0, start = 1'b0, pause = 1'b0;
  logic [9:0]  p1_y = 10'd400, p2_y = 10'd400;
  logic [10:0] ball_x;
  logic [9:0]  ball_y;
  logic [3:0]  score1, score2;
  logic [2:0]  state_o;
  logic        ball_active, game_over, winner;

  int vectors = 0, miscompares = 0;

  // Model state: players are numbered 1 and 2, directions 0=left/up 1=right/down.
  int mst, mx, my, mdx, mdy, mvx, mvy, mcnt, ms1, ms2, mscorer, mwin;

  always #5 clk = ~clk;

  pong_ball_engine dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
    .p1_y(p1_y), .p2_y(p2_y), .ball_x(ball_x), .ball_y(ball_y),
    .score1(score1), .score2(score2), .state_o(state_o),
    .ball_active(ball_active), .game_over(game_over), .winner(winner)
  );

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_recentre();
    mx = CX; my = CY; mvx = SPD_INIT; mvy = SPD_INIT; mdy = 0; mcnt = SERVE_TICKS;
  endfunction

  function automatic void model_reset();
    mst = S_IDLE; mx = CX; my = CY; mdx = 1; mdy = 0; mvx = SPD_INIT; mvy = SPD_INIT;
    mcnt = 0; ms1 = 0; ms2 = 0; mscorer = 1; mwin = 1;
  endfunction

  function automatic void model_step(input bit st, input bit ps, input bit tk,
                                     input int p1, input int p2);
    int cy, pad, off;
    bit h1, h2;
    case (mst)
      S_IDLE: if (st) begin mst = S_SERVE; mcnt = SERVE_TICKS; end
      S_SERVE: if (tk && !ps) begin
        if (mcnt <= 1) begin mst = S_MOVE; mcnt = 0; end
        else mcnt = mcnt - 1;
      end
      S_MOVE: if (tk && !ps) begin
        cy = my + BALL / 2;
        h1 = (mdx == 0) && (mx < P1_X + PAD_W) && (mx + BALL > P1_X) && (cy >= p1) && (cy < p1 + PAD_H);
        h2 = (mdx == 1) && (mx < P2_X + PAD_W) && (mx + BALL > P2_X) && (cy >= p2) && (cy < p2 + PAD_H);
        if (h1 || h2) begin
          pad = h1 ? p1 : p2;
          mdx = h1 ? 1 : 0;
          mx  = h1 ? P1_X + PAD_W : P2_X - BALL;
          mvx = imin(mvx + 1, SPD_MAX);
          off = cy - pad;
          if (off < PAD_H / 3) begin mdy = 0; mvy = imin(mvy + 1, SPD_MAX); end
          else if (off >= 2 * PAD_H / 3) begin mdy = 1; mvy = imin(mvy + 1, SPD_MAX); end
        end else if (mdx == 0 && mx < mvx) begin
          mst = S_SCORE; mscorer = 2;
        end else if (mdx == 1 && mx + mvx > H_RES - BALL) begin
          mst = S_SCORE; mscorer = 1;
        end else begin
          mx = (mdx == 1) ? mx + mvx : mx - mvx;
          if (mdy == 0) begin
            if (my <= mvy) begin my = 0; mdy = 1; end else my = my - mvy;
          end else begin
            if (my + mvy >= V_RES - BALL) begin my = V_RES - BALL; mdy = 0; end
            else my = my + mvy;
          end
        end
      end
      S_SCORE: begin
        if (mscorer == 1) ms1++; else ms2++;
        if (((mscorer == 1) ? ms1 : ms2) == SCORE_MAX) begin
          mst = S_OVER; mwin = mscorer;
        end else begin
          model_recentre();
          mdx = (mscorer == 1) ? 1 : 0;
          mst = S_SERVE;
        end
      end
      S_OVER: if (st) begin
        ms1 = 0; ms2 = 0; model_recentre(); mdx = 1; mst = S_SERVE;
      end
      default: mst = S_IDLE;
    endcase
  endfunction

  task automatic check_all(input string tag);
    bit bad;
    bad = (int'(state_o) != mst) || (int'(ball_x) != mx) || (int'(ball_y) != my) ||
          (int'(score1) != ms1) || (int'(score2) != ms2) ||
          (ball_active != (mst == S_MOVE)) || (game_over != (mst == S_OVER)) ||
          ((mst == S_OVER) && (winner != (mwin == 2)));
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s @%0t: got st=%0d x=%0d y=%0d s1=%0d s2=%0d act=%0b over=%0b win=%0b; expected st=%0d x=%0d y=%0d s1=%0d s2=%0d win=%0d",
               tag, $time, state_o, ball_x, ball_y, score1, score2, ball_active, game_over, winner,
               mst, mx, my, ms1, ms2, mwin - 1);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // One clock: drive at negedge, model advances at posedge, compare at next negedge.
  task automatic cycle(input bit st, input bit ps, input bit tk, input string tag);
    start = st; pause = ps; tick = tk;
    @(posedge clk);
    model_step(st, ps, tk, int'(p1_y), int'(p2_y));
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    model_reset();
    #1;
    check_all("reset_async");
    @(posedge clk);
    @(negedge clk);
    check_all("reset_held");
    reset = 1'b1;
  endtask

  function automatic int track(input int y);
    int p;
    p = y + BALL / 2 - int'($urandom_range(0, PAD_H - 1));
    if (p < 0) p = 0;
    if (p > V_RES - PAD_H) p = V_RES - PAD_H;
    return p;
  endfunction

  // One side follows the ball, the other stays clear of it, until match end.
  task automatic play_to_over(input int trk_side, input string tag);
    int n;
    n = 0;
    if (mst == S_IDLE || mst == S_OVER) cycle(1'b1, 1'b0, 1'b0, tag);
    while (mst != S_OVER && n < 20000) begin
      if (trk_side == 2) begin
        p2_y = 10'(track(my));
        p1_y = (my > 200) ? 10'd0 : 10'd430;
      end else begin
        p1_y = 10'(track(my));
        p2_y = (my > 200) ? 10'd0 : 10'd430;
      end
      cycle(1'b0, 1'b0, 1'b1, tag);
      n++;
    end
    if (mst != S_OVER) begin
      vectors++; miscompares++;
      $display("FAIL %s: match did not end within budget, got state %0d, expected %0d", tag, mst, S_OVER);
    end
  endtask

  typedef struct {
    bit st; bit ps; bit tk;
    int e_state; int e_x; int e_y; int e_s1; int e_s2;
  } vec_t;

  vec_t tbl[7];
  int   sx, sy;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, S_IDLE,  CX, CY, 0, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, S_IDLE,  CX, CY, 0, 0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, S_IDLE,  CX, CY, 0, 0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, S_SERVE, CX, CY, 0, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, S_SERVE, CX, CY, 0, 0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, S_SERVE, CX, CY, 0, 0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, S_SERVE, CX, CY, 0, 0};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].st, tbl[i].ps, tbl[i].tk, "table");
      check_val($sformatf("tbl%0d_state", i), int'(state_o), tbl[i].e_state);
      check_val($sformatf("tbl%0d_xy", i), int'(ball_x) * 1000 + int'(ball_y), tbl[i].e_x * 1000 + tbl[i].e_y);
      check_val($sformatf("tbl%0d_score", i), int'(score1) * 16 + int'(score2), tbl[i].e_s1 * 16 + tbl[i].e_s2);
    end

    // Serve countdown: paused ticks above must not have counted.
    for (int k = 1; k <= SERVE_TICKS; k++) begin
      cycle(1'b0, 1'b0, 1'b1, "serve");
      if (k == SERVE_TICKS - 1) check_val("serve_tick59_state", int'(state_o), S_SERVE);
      if (k == SERVE_TICKS) check_val("serve_tick60_state", int'(state_o), S_MOVE);
    end
    cycle(1'b0, 1'b0, 1'b1, "first_move");
    check_val("first_move_x", int'(ball_x), 316);
    check_val("first_move_y", int'(ball_y), 234);
    check_val("first_move_active", int'(ball_active), 1);

    // Reset in the middle of play.
    repeat (5) cycle(1'b0, 1'b0, 1'b1, "pre_reset");
    do_reset();
    check_val("midplay_reset_state", int'(state_o), S_IDLE);
    check_val("midplay_reset_x", int'(ball_x), CX);
    check_val("midplay_reset_active", int'(ball_active), 0);

    // Full flight to the top wall and on to a P1 goal on the right.
    cycle(1'b1, 1'b0, 1'b0, "restart");
    repeat (SERVE_TICKS) cycle(1'b0, 1'b0, 1'b1, "serve2");
    for (int k = 1; k <= 316; k++) begin
      cycle(1'b0, 1'b0, 1'b1, "flight");
      if (k == 234) begin check_val("pre_wall_x", int'(ball_x), 549); check_val("pre_wall_y", int'(ball_y), 1); end
      if (k == 235) check_val("wall_y", int'(ball_y), 0);
      if (k == 236) check_val("after_wall_y", int'(ball_y), 1);
      if (k == 316) check_val("goal_state", int'(state_o), S_SCORE);
    end
    cycle(1'b0, 1'b0, 1'b0, "score_p1");
    check_val("score_p1_s1", int'(score1), 1);
    check_val("score_p1_state", int'(state_o), S_SERVE);
    check_val("score_p1_x", int'(ball_x), CX);

    // Pause freezes the serve count.
    repeat (10) cycle(1'b0, 1'b1, 1'b1, "pause_hold");
    for (int k = 1; k <= SERVE_TICKS; k++) begin
      cycle(1'b0, 1'b0, 1'b1, "serve3");
      if (k == SERVE_TICKS - 1) check_val("paused_serve_state", int'(state_o), S_SERVE);
      if (k == SERVE_TICKS) check_val("paused_launch_state", int'(state_o), S_MOVE);
    end

    // Randomised play against the model.
    for (int i = 0; i < 20000; i++) begin
      if (i % 8 == 0) begin
        p1_y = ($urandom_range(0, 1) == 1) ? 10'(track(my)) : 10'($urandom_range(0, V_RES - PAD_H));
        p2_y = ($urandom_range(0, 1) == 1) ? 10'(track(my)) : 10'($urandom_range(0, V_RES - PAD_H));
      end
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, "rand");
    end

    // P2 takes the match; OVER holds; start restarts.
    play_to_over(2, "p2_match");
    check_val("p2_over_flag", int'(game_over), 1);
    check_val("p2_winner", int'(winner), 1);
    check_val("p2_final_score", int'(score2), SCORE_MAX);
    sx = int'(ball_x); sy = int'(ball_y);
    repeat (5) cycle(1'b0, 1'b0, 1'b1, "over_hold");
    check_val("over_hold_x", int'(ball_x), sx);
    check_val("over_hold_y", int'(ball_y), sy);
    check_val("over_hold_state", int'(state_o), S_OVER);
    cycle(1'b1, 1'b0, 1'b0, "over_restart");
    check_val("restart_state", int'(state_o), S_SERVE);
    check_val("restart_scores", int'(score1) * 16 + int'(score2), 0);
    check_val("restart_over_flag", int'(game_over), 0);

    // P1 takes the next match.
    play_to_over(1, "p1_match");
    check_val("p1_winner", int'(winner), 0);
    check_val("p1_final_score", int'(score1), SCORE_MAX);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
